// File: rtl/step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_ctrl_pkg
// Description : Shared types and constants for the CPU step controller.
//               - state_t     : controller state encoding
//                               (HALT=0, RUN=1, STEP=2, BURST=3)
//               - DIV_WIDTH   : prescaler counter / divisor width
//               - DIV_DEFAULT : divisor value loaded at reset
// Revision    : 1.0 - initial release
// ============================================================================
package step_ctrl_pkg;

    localparam int DIV_WIDTH = 25;
    localparam logic [DIV_WIDTH-1:0] DIV_DEFAULT = 25'd13500000;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

endpackage : step_ctrl_pkg
`default_nettype wire

// File: rtl/cpu_step_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller_if
// Description : Request / status bundle of the CPU step controller.
//               master : drives run/step/burst requests and divisor loads,
//                        observes cpu_ce, busy, state_o, burst_done.
//               slave  : the controller side (opposite directions).
//               Optional macro STEP_COUNTER_EN adds the 32-bit tick_count.
// Ports       : none (signal container only)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_controller_if #(
    parameter int DIV_WIDTH = step_ctrl_pkg::DIV_WIDTH
) ();

    logic                 run_req;
    logic                 step_req;
    logic                 burst_req;
    logic [7:0]           burst_len;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_value;
    logic                 cpu_ce;
    logic                 busy;
    logic [1:0]           state_o;
    logic                 burst_done;
`ifdef STEP_COUNTER_EN
    logic [31:0]          tick_count;
`endif

    modport master (
        output run_req, step_req, burst_req, burst_len, div_load, div_value,
        input  cpu_ce, busy, state_o, burst_done
`ifdef STEP_COUNTER_EN
        , input tick_count
`endif
    );

    modport slave (
        input  run_req, step_req, burst_req, burst_len, div_load, div_value,
        output cpu_ce, busy, state_o, burst_done
`ifdef STEP_COUNTER_EN
        , output tick_count
`endif
    );

endinterface : cpu_step_controller_if
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_tick_gen
// Description : Prescaler. Counts up while enabled and produces a tick in
//               the cycle the count equals div_reg, then wraps to 0, giving
//               one tick every div_reg+1 enabled cycles. The count is held
//               at 0 while disabled and forced to 0 by clear.
// Ports       : clk_in   - clock (posedge)
//               reset_in - asynchronous active-high reset
//               enable   - count enable (controller in RUN or BURST)
//               clear    - synchronous counter clear (divisor reload)
//               div_reg  - current divisor
//               tick     - combinational tick, valid while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int WIDTH = 25
) (
    input  wire logic             clk_in,
    input  wire logic             reset_in,
    input  wire logic             enable,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] div_reg,
    output logic                  tick
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    assign tick = enable && (r_count == div_reg);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_count <= '0;
        end else if (clear || !enable || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

endmodule : step_tick_gen
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller
// Description : Generates a one-cycle CPU clock-enable (cpu_ce) in free-run,
//               single-step or counted-burst mode, paced by a programmable
//               prescaler (tick period = divisor + 1 cycles).
// Ports       : clk_in   - clock (posedge)
//               reset_in - asynchronous active-high reset
//               bus      - cpu_step_controller_if.slave:
//                   run_req, step_req, burst_req, burst_len[7:0],
//                   div_load, div_value[DIV_WIDTH-1:0]          (inputs)
//                   cpu_ce, busy, state_o[1:0], burst_done      (outputs)
//                   tick_count[31:0]  (only with STEP_COUNTER_EN)
// Macro       : STEP_COUNTER_EN - adds a 32-bit count of cpu_ce pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_controller #(
    parameter int                   DIV_WIDTH   = step_ctrl_pkg::DIV_WIDTH,
    parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = step_ctrl_pkg::DIV_DEFAULT
) (
    input  wire logic            clk_in,
    input  wire logic            reset_in,
    cpu_step_controller_if.slave bus
);

    import step_ctrl_pkg::*;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_div_reg;
    logic [7:0]           r_remaining;
    logic                 r_cpu_ce;
    logic                 r_burst_done;

    logic                 w_tick;
    logic                 w_tick_ok;
    logic                 w_presc_en;

    assign w_presc_en = (r_state == ST_RUN) || (r_state == ST_BURST);
    // A divisor reload in the same cycle as a tick swallows that tick.
    assign w_tick_ok  = w_tick && !bus.div_load;

    step_tick_gen #(
        .WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .enable   (w_presc_en),
        .clear    (bus.div_load),
        .div_reg  (r_div_reg),
        .tick     (w_tick)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= ST_HALT;
            r_div_reg    <= DIV_DEFAULT;
            r_remaining  <= 8'd0;
            r_cpu_ce     <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_cpu_ce     <= 1'b0;
            r_burst_done <= 1'b0;

            if (bus.div_load) begin
                r_div_reg <= bus.div_value;
            end

            case (r_state)
                ST_HALT: begin
                    if (bus.run_req) begin
                        r_state <= ST_RUN;
                    end else if (bus.step_req) begin
                        r_state <= ST_STEP;
                    end else if (bus.burst_req && (bus.burst_len != 8'd0)) begin
                        r_state     <= ST_BURST;
                        r_remaining <= bus.burst_len;
                    end
                end

                ST_RUN: begin
                    // Dropping run_req wins over any tick in the same cycle.
                    if (!bus.run_req) begin
                        r_state <= ST_HALT;
                    end else if (w_tick_ok) begin
                        r_cpu_ce <= 1'b1;
                    end
                end

                ST_STEP: begin
                    r_cpu_ce <= 1'b1;
                    r_state  <= ST_HALT;
                end

                ST_BURST: begin
                    if (w_tick_ok) begin
                        r_cpu_ce    <= 1'b1;
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_burst_done <= 1'b1;
                            r_state      <= ST_HALT;
                        end
                    end
                end

                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.cpu_ce     = r_cpu_ce;
    assign bus.burst_done = r_burst_done;
    assign bus.state_o    = r_state;
    assign bus.busy       = (r_state != ST_HALT);

`ifdef STEP_COUNTER_EN
    logic [31:0] r_tick_count;

    // Counts the registered pulse, so it trails cpu_ce by one cycle.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_tick_count <= 32'd0;
        end else if (r_cpu_ce) begin
            r_tick_count <= r_tick_count + 32'd1;
        end
    end

    assign bus.tick_count = r_tick_count;
`endif

endmodule : cpu_step_controller
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_controller
// Description : Directed self-checking bench for cpu_step_controller.
//               Inputs change 1 ns after a rising edge; outputs are
//               sampled at the same point, one cycle per tick() call.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_controller;

    logic clk_in = 1'b0;
    logic reset_in;
    int   n_asserts = 0;
    int   n_fail    = 0;

    cpu_step_controller_if #(.DIV_WIDTH(25)) bus ();

    cpu_step_controller #(
        .DIV_WIDTH   (25),
        .DIV_DEFAULT (25'd13500000)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_div(input logic [24:0] v);
        bus.div_load  = 1'b1;
        bus.div_value = v;
        tick();
        bus.div_load  = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        bus.run_req   = 1'b0;
        bus.step_req  = 1'b0;
        bus.burst_req = 1'b0;
        bus.burst_len = 8'd0;
        bus.div_load  = 1'b0;
        bus.div_value = 25'd0;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ce", 32'(bus.cpu_ce), 32'd0);
        chk("rst_done", 32'(bus.burst_done), 32'd0);
        reset_in = 1'b0;
        tick();

        // Free run with divisor 3: pulses at entry+4, +8, +12, +16
        load_div(25'd3);
        bus.run_req = 1'b1;
        tick();
        chk("run3_state", 32'(bus.state_o), 32'd1);
        chk("run3_busy", 32'(bus.busy), 32'd1);
        chk("run3_ce_k0", 32'(bus.cpu_ce), 32'd0);
        for (int k = 1; k <= 19; k++) begin
            tick();
            chk($sformatf("run3_ce_k%0d", k), 32'(bus.cpu_ce), 32'((k % 4) == 0));
        end
        bus.run_req = 1'b0;
        tick();   // the tick pending on this edge must be discarded
        chk("run3_stop_ce", 32'(bus.cpu_ce), 32'd0);
        chk("run3_stop_state", 32'(bus.state_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("run3_idle_ce%0d", k), 32'(bus.cpu_ce), 32'd0);
        end

        // Single step
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        chk("step_state", 32'(bus.state_o), 32'd2);
        chk("step_busy", 32'(bus.busy), 32'd1);
        chk("step_ce0", 32'(bus.cpu_ce), 32'd0);
        tick();
        chk("step_ce1", 32'(bus.cpu_ce), 32'd1);
        chk("step_busy1", 32'(bus.busy), 32'd0);
        chk("step_state1", 32'(bus.state_o), 32'd0);
        tick();
        chk("step_ce2", 32'(bus.cpu_ce), 32'd0);

        // Burst of 5 with divisor 1: pulses at entry+2,4,6,8,10
        load_div(25'd1);
        bus.burst_req = 1'b1;
        bus.burst_len = 8'd5;
        tick();
        bus.burst_req = 1'b0;
        bus.burst_len = 8'd0;
        chk("burst_state", 32'(bus.state_o), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("burst_ce_k%0d", k), 32'(bus.cpu_ce), 32'(((k % 2) == 0) && (k <= 10)));
            chk($sformatf("burst_done_k%0d", k), 32'(bus.burst_done), 32'(k == 10));
            chk($sformatf("burst_state_k%0d", k), 32'(bus.state_o), (k < 10) ? 32'd3 : 32'd0);
        end

        // Zero-length burst is ignored
        bus.burst_req = 1'b1;
        bus.burst_len = 8'd0;
        tick();
        bus.burst_req = 1'b0;
        chk("burst0_state", 32'(bus.state_o), 32'd0);
        chk("burst0_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("burst0_ce", 32'(bus.cpu_ce), 32'd0);

        // step/burst requests dropped during RUN (divisor 1)
        bus.run_req = 1'b1;
        tick();
        chk("runx_state0", 32'(bus.state_o), 32'd1);
        bus.step_req  = 1'b1;
        bus.burst_req = 1'b1;
        bus.burst_len = 8'd3;
        tick();
        bus.step_req  = 1'b0;
        bus.burst_req = 1'b0;
        bus.burst_len = 8'd0;
        chk("runx_state1", 32'(bus.state_o), 32'd1);
        chk("runx_ce1", 32'(bus.cpu_ce), 32'd0);
        tick();
        chk("runx_ce2", 32'(bus.cpu_ce), 32'd1);
        chk("runx_state2", 32'(bus.state_o), 32'd1);
        bus.run_req = 1'b0;
        tick();
        chk("runx_state3", 32'(bus.state_o), 32'd0);
        chk("runx_ce3", 32'(bus.cpu_ce), 32'd0);
        tick();
        chk("runx_state4", 32'(bus.state_o), 32'd0);

        // run_req ignored during BURST (len 2, divisor 1)
        bus.burst_req = 1'b1;
        bus.burst_len = 8'd2;
        tick();
        bus.burst_req = 1'b0;
        bus.burst_len = 8'd0;
        bus.run_req   = 1'b1;
        tick();
        bus.run_req   = 1'b0;
        chk("brun_state1", 32'(bus.state_o), 32'd3);
        tick();
        chk("brun_ce2", 32'(bus.cpu_ce), 32'd1);
        chk("brun_state2", 32'(bus.state_o), 32'd3);
        tick();
        chk("brun_state3", 32'(bus.state_o), 32'd3);
        tick();
        chk("brun_ce4", 32'(bus.cpu_ce), 32'd1);
        chk("brun_done4", 32'(bus.burst_done), 32'd1);
        chk("brun_state4", 32'(bus.state_o), 32'd0);

        // Reset asserted mid-burst, while cpu_ce is high
        bus.burst_req = 1'b1;
        bus.burst_len = 8'd8;
        tick();
        bus.burst_req = 1'b0;
        bus.burst_len = 8'd0;
        tick();
        tick();
        chk("mrst_ce_before", 32'(bus.cpu_ce), 32'd1);
        #2;
        reset_in = 1'b1;
        #1;
        chk("mrst_ce", 32'(bus.cpu_ce), 32'd0);
        chk("mrst_state", 32'(bus.state_o), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        tick();
        reset_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mrst_after_ce%0d", k), 32'(bus.cpu_ce), 32'd0);
            chk($sformatf("mrst_after_state%0d", k), 32'(bus.state_o), 32'd0);
        end

        // Divisor 0: cpu_ce continuously high in RUN
        load_div(25'd0);
        bus.run_req = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("run0_ce_k%0d", k), 32'(bus.cpu_ce), 32'd1);
        end
        bus.run_req = 1'b0;
        tick();
        chk("run0_stop_ce", 32'(bus.cpu_ce), 32'd0);
        chk("run0_stop_state", 32'(bus.state_o), 32'd0);

        // div_load (4) coincident with the second tick at divisor 2:
        // pulse at entry+3, suppressed at +6, next at +6+5 = +11
        load_div(25'd2);
        bus.run_req = 1'b1;
        tick();
        for (int k = 1; k <= 11; k++) begin
            tick();
            bus.div_load = 1'b0;
            chk($sformatf("dload_ce_k%0d", k), 32'(bus.cpu_ce), 32'((k == 3) || (k == 11)));
            if (k == 5) begin
                bus.div_load  = 1'b1;
                bus.div_value = 25'd4;
            end
        end
        bus.run_req = 1'b0;
        tick();
        chk("dload_stop_state", 32'(bus.state_o), 32'd0);

`ifdef STEP_COUNTER_EN
        // 5 pulses at divisor 0 plus 2 in the reload test since the last reset
        tick();
        chk("tick_count", bus.tick_count, 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_cpu_step_controller
`default_nettype wire

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 25, prescaler counter and divisor width.
REQ-002 SHALL have parameter DIV_DEFAULT, default 25'd13500000, divisor loaded at reset.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run_req  input  1  level; high requests free-run.
REQ-006 SHALL have port step_req  input  1  single-cycle pulse; requests one CPU step.
REQ-007 SHALL have port burst_req  input  1  single-cycle pulse; requests burst_len steps.
REQ-008 SHALL have port burst_len  input  8  step count, sampled with burst_req.
REQ-009 SHALL have port div_load  input  1  pulse; loads div_value into the divisor register.
REQ-010 SHALL have port div_value  input  DIV_WIDTH  new divisor (tick period = div_value+1 cycles).
REQ-011 SHALL have port cpu_ce  output  1  registered CPU clock-enable pulse, one cycle wide.
REQ-012 SHALL have port busy  output  1  high whenever state != HALT.
REQ-013 SHALL have port state_o  output  2  current state encoding.
REQ-014 SHALL have port burst_done  output  1  registered pulse when a burst completes.

Function
REQ-015 SHALL implement states HALT=0, RUN=1, STEP=2, BURST=3.
REQ-016 Prescaler SHALL be held at 0 in HALT and STEP, increment in RUN/BURST, and wrap to 0 when equal to div_reg (tick).
REQ-017 On a tick, cpu_ce SHALL be 1 in the following cycle; the first cpu_ce after entering RUN/BURST arrives div_reg+1 cycles after entry.
REQ-018 div_reg=0 SHALL give a tick every cycle (cpu_ce continuously high in RUN).
REQ-019 HALT transitions, by priority: run_req=1 -> RUN; step_req -> STEP; burst_req with burst_len!=0 -> BURST; burst_len=0 is ignored.
REQ-020 RUN SHALL return to HALT the cycle after run_req is sampled low; a pending tick is discarded.
REQ-021 STEP SHALL assert cpu_ce for exactly one cycle (the cycle after entry) and then return to HALT.
REQ-022 BURST SHALL load the remaining count from burst_len on entry, decrement it on each cpu_ce, and, on the cpu_ce taking it to 0, pulse burst_done in the same cycle and enter HALT.
REQ-023 step_req and burst_req outside HALT SHALL be dropped; run_req SHALL be ignored during BURST.
REQ-024 div_load SHALL be accepted in any state: div_reg updates and the prescaler clears next cycle, with no tick generated that cycle.
REQ-025 Simultaneous div_load and a tick SHALL suppress the tick.

Reset
REQ-026 reset_in high SHALL asynchronously force state=HALT, prescaler=0, div_reg=DIV_DEFAULT, remaining=0, cpu_ce=0, burst_done=0, busy=0, state_o=0.
REQ-027 Reset mid-RUN/BURST SHALL abort without any further cpu_ce; after release the block stays in HALT until a new request.

Configuration
REQ-028 With STEP_COUNTER_EN defined, SHALL add output tick_count (32 bits, reset 0), incrementing on every cpu_ce and wrapping 0xFFFFFFFF->0.
REQ-029 Without STEP_COUNTER_EN, tick_count and its counter SHALL be absent.

Structure
REQ-030 Package step_ctrl_pkg SHALL hold the state enum, DIV_WIDTH and DIV_DEFAULT constants.
REQ-031 The prescaler SHALL be a sub-module, step_tick_gen (inputs: enable, clear, div_reg; output: tick).

Verification
REQ-032 div_load with 3, run_req=1 for 20 cycles -> cpu_ce at entry+4, +8, +12, +16; no cpu_ce after run_req falls.
REQ-033 step_req pulse in HALT -> exactly one cpu_ce, 2 cycles after the pulse; busy high for one cycle.
REQ-034 div=1, burst_req with burst_len=5 -> 5 cpu_ce pulses 2 cycles apart, burst_done coincident with the 5th, then HALT; burst_len=0 -> no activity.
REQ-035 step_req and burst_req during RUN -> ignored; reset_in asserted mid-BURST -> cpu_ce=0 immediately, state_o=0.
REQ-036 div_load coincident with a tick in RUN -> that cpu_ce suppressed, next at new div+1 cycles; with STEP_COUNTER_EN, tick_count equals the number of cpu_ce pulses.
